// File: rtl/rtc_tick_gen_if.sv
// rtl/rtc_tick_gen_if.sv - run/fast controls and timebase outputs of the RTC tick generator
interface rtc_tick_gen_if;
   logic       btn_run;
   logic       fast;
   logic       clk_1hz;
   logic       tick;
   logic       running;
   logic [1:0] mode;

   modport master (
      output btn_run, fast,
      input  clk_1hz, tick, running, mode
   );

   modport slave (
      input  btn_run, fast,
      output clk_1hz, tick, running, mode
   );
endinterface

// File: rtl/rtc_tick_gen.sv
// rtl/rtc_tick_gen.sv - 1 Hz / fast timebase with debounced run/stop toggle
module rtc_tick_gen #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FAST_HZ    = 64,
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic            clk,
   input  logic            rst_n,
   rtc_tick_gen_if.slave   bus
);
   localparam int CW = $clog2(CLK_HZ);
   localparam int DW = $clog2(DEB_CYCLES + 1);

   localparam logic [CW-1:0] RUN_LAST  = CW'(CLK_HZ - 1);
   localparam logic [CW-1:0] RUN_HALF  = CW'(CLK_HZ / 2 - 1);
   localparam logic [CW-1:0] FAST_LAST = CW'(CLK_HZ / FAST_HZ - 1);
   localparam logic [CW-1:0] FAST_HALF = CW'(CLK_HZ / FAST_HZ / 2 - 1);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_STOP = 2'd0,
      ST_RUN  = 2'd1,
      ST_FAST = 2'd2
   } mode_t;

   logic          btn_meta, btn_sync;
   logic          fast_meta, fast_sync;
   logic          deb_level, deb_prev;
   logic [DW-1:0] deb_cnt;
   logic          press;
   logic          running;
   mode_t         state, mode_next;
   logic [CW-1:0] cnt, last, half;
   logic          clk_1hz_r, tick_r;

   // Two-flop synchronizers for the asynchronous button and fast switch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta  <= 1'b0;
         btn_sync  <= 1'b0;
         fast_meta <= 1'b0;
         fast_sync <= 1'b0;
      end else begin
         btn_meta  <= bus.btn_run;
         btn_sync  <= btn_meta;
         fast_meta <= bus.fast;
         fast_sync <= fast_meta;
      end
   end

   // Debounce: level follows the synced button only after DEB_CYCLES steady differing cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_level <= 1'b0;
         deb_prev  <= 1'b0;
         deb_cnt   <= '0;
      end else begin
         deb_prev <= deb_level;
         if (btn_sync == deb_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_level <= btn_sync;
            deb_cnt   <= '0;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

   // A press is the debounced rising edge; release does nothing
   assign press = deb_level & ~deb_prev;

   // Run flag toggles on every press, including presses made in fast mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
      end else if (press) begin
         running <= ~running;
      end
   end

   // Next mode: fast overrides, otherwise the run flag selects run or stop
   always_comb begin
      mode_next = ST_STOP;
      if (fast_sync) begin
         mode_next = ST_FAST;
      end else if (running) begin
         mode_next = ST_RUN;
      end
   end

   assign last = (state == ST_FAST) ? FAST_LAST : RUN_LAST;
   assign half = (state == ST_FAST) ? FAST_HALF : RUN_HALF;

   // Mode FSM and divider: a mode change discards the phase so the first tick is a full period later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_STOP;
         cnt       <= '0;
         clk_1hz_r <= 1'b0;
         tick_r    <= 1'b0;
      end else if (mode_next != state) begin
         state     <= mode_next;
         cnt       <= '0;
         clk_1hz_r <= 1'b0;
         tick_r    <= 1'b0;
      end else if (state == ST_STOP) begin
         cnt       <= '0;
         clk_1hz_r <= 1'b0;
         tick_r    <= 1'b0;
      end else if (cnt == last) begin
         cnt       <= '0;
         clk_1hz_r <= 1'b1;
         tick_r    <= 1'b1;
      end else begin
         cnt    <= cnt + CW'(1);
         tick_r <= 1'b0;
         if (cnt == half) begin
            clk_1hz_r <= 1'b0;
         end
      end
   end

   assign bus.clk_1hz = clk_1hz_r;
   assign bus.tick    = tick_r;
   assign bus.running = running;
   assign bus.mode    = state;
endmodule

// File: tb/tb_rtc_tick_gen.sv
// tb/tb_rtc_tick_gen.sv - directed self-checking bench for rtc_tick_gen
module tb_rtc_tick_gen;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   rtc_tick_gen_if bus ();

   rtc_tick_gen #(
      .CLK_HZ     (20),
      .FAST_HZ    (5),
      .DEB_CYCLES (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int bad;
      int secs;
      int carries;
      int ticks;

      rst_n       = 1'b0;
      bus.btn_run = 1'b0;
      bus.fast    = 1'b0;
      step(3);
      chk("reset_mode", bus.mode, 0);
      chk("reset_clk_1hz", bus.clk_1hz, 0);
      chk("reset_tick", bus.tick, 0);
      chk("reset_running", bus.running, 0);
      rst_n = 1'b1;

      // 1: idle for 100 cycles
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step(1);
         if (bus.mode !== 2'd0 || bus.clk_1hz !== 1'b0 || bus.tick !== 1'b0 || bus.running !== 1'b0)
            bad++;
      end
      chk("idle_outputs", bad, 0);

      // 2: press and hold; running after 2 sync + 4 debounce + 1 toggle
      bus.btn_run = 1'b1;
      n = 0;
      while (bus.running !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      chk("run_latency", n, 7);
      step(1);
      chk("mode_run", bus.mode, 1);
      n = 0;
      do begin
         step(1);
         n++;
         if (n == 2) bus.btn_run = 1'b0;
      end while (bus.tick !== 1'b1 && n < 40);
      chk("first_tick_run", n, 20);
      chk("clk_rise_with_tick", bus.clk_1hz, 1);
      n = 0;
      while (bus.clk_1hz === 1'b1 && n < 40) begin
         step(1);
         n++;
      end
      chk("run_high_time", n, 10);
      n = 0;
      while (bus.clk_1hz === 1'b0 && n < 40) begin
         step(1);
         n++;
      end
      chk("run_low_time", n, 10);
      chk("tick_at_rise", bus.tick, 1);
      n = 0;
      do begin
         step(1);
         n++;
      end while (bus.tick !== 1'b1 && n < 40);
      chk("run_period", n, 20);

      // 3: bounce must not toggle running
      bus.btn_run = 1'b1; step(1);
      bus.btn_run = 1'b0; step(1);
      bus.btn_run = 1'b1; step(1);
      bus.btn_run = 1'b0; step(20);
      chk("bounce_running", bus.running, 1);
      chk("bounce_mode", bus.mode, 1);

      // 4: fast mode and back
      bus.fast = 1'b1;
      n = 0;
      while (bus.mode !== 2'd2 && n < 20) begin
         step(1);
         n++;
      end
      chk("fast_latency", n, 3);
      chk("fast_entry_clk", bus.clk_1hz, 0);
      n = 0;
      do begin
         step(1);
         n++;
      end while (bus.tick !== 1'b1 && n < 40);
      chk("first_tick_fast", n, 4);
      n = 0;
      while (bus.clk_1hz === 1'b1 && n < 40) begin
         step(1);
         n++;
      end
      chk("fast_high_time", n, 2);
      n = 0;
      while (bus.clk_1hz === 1'b0 && n < 40) begin
         step(1);
         n++;
      end
      chk("fast_low_time", n, 2);
      chk("fast_tick_at_rise", bus.tick, 1);
      bus.fast = 1'b0;
      step(3);
      chk("back_to_run", bus.mode, 1);
      n = 0;
      do begin
         step(1);
         n++;
      end while (bus.tick !== 1'b1 && n < 40);
      chk("tick_after_fast", n, 20);

      // 5: asynchronous reset in the high half of a period
      step(3);
      chk("pre_reset_clk", bus.clk_1hz, 1);
      rst_n = 1'b0;
      #1;
      chk("async_running", bus.running, 0);
      chk("async_mode", bus.mode, 0);
      chk("async_clk_1hz", bus.clk_1hz, 0);
      chk("async_tick", bus.tick, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(30);
      chk("post_reset_running", bus.running, 0);
      chk("post_reset_mode", bus.mode, 0);

      // 6: drive a mod-60 seconds counter for 1200 cycles
      bus.btn_run = 1'b1;
      n = 0;
      while (bus.mode !== 2'd1 && n < 30) begin
         step(1);
         n++;
      end
      chk("restart_latency", n, 8);
      bus.btn_run = 1'b0;
      secs = 0;
      carries = 0;
      ticks = 0;
      for (int i = 0; i < 1200; i++) begin
         step(1);
         if (bus.tick === 1'b1) begin
            ticks++;
            if (secs == 59) begin
               secs = 0;
               carries++;
            end else begin
               secs++;
            end
         end
      end
      chk("sec_ticks", ticks, 60);
      chk("sec_carries", carries, 1);
      chk("sec_value", secs, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
